// File: rtl/dpi_seq_pkg.sv
// Shared types and constants for the DPI packet sequencer.
package dpi_seq_pkg;
  localparam int NUM_CAT_D = 8;
  localparam int SID_W_D   = 6;

  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_EOP} state_e;

  // Byte 0 of a word is the most significant byte.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    case (l)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction
endpackage

// File: rtl/dpi_stream_table.sv
// Seen-bitmap for stream IDs; read is combinational so the current ID reports its pre-update value.
module dpi_stream_table import dpi_seq_pkg::*; #(
  parameter int SID_W = SID_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SID_W-1:0] rd_sid,
  output logic             rd_seen,
  input  logic             set_en,
  input  logic             clr_all
);
  logic [2**SID_W-1:0] r_seen;

  assign rd_seen = r_seen[rd_sid];

  // The per-ID set is ordered after the global clear so it survives a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen <= '0;
    end else begin
      if (clr_all) r_seen <= '0;
      if (set_en)  r_seen[rd_sid] <= 1'b1;
    end
  end
endmodule

// File: rtl/dpi_pkt_sequencer.sv
// Turns a 32-bit packet word stream into load_state / byte stream / eop sequences for the matchers.
module dpi_pkt_sequencer import dpi_seq_pkg::*; #(
  parameter int NUM_CAT = NUM_CAT_D,
  parameter int SID_W   = SID_W_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [1:0]         in_nbytes,
  input  logic [SID_W-1:0]   in_sid,
  input  logic [NUM_CAT-1:0] in_en_mask,
  input  logic               clr_streams,
  output logic               load_state,
  output logic               new_stream_id,
  output logic [SID_W-1:0]   stream_id,
  output logic [7:0]         char_in,
  output logic               char_in_vld,
  output logic               eop,
  output logic [NUM_CAT-1:0] enable,
  output logic [15:0]        pkt_count,
  output logic               busy
);
  state_e r_state, w_nxt;

  logic               r_live;
  logic [31:0]        r_hold, r_skid;
  logic               r_hold_vld, r_hold_eop, r_skid_vld, r_skid_sop, r_skid_eop;
  logic [1:0]         r_hold_nb, r_skid_nb, r_lane;
  logic [SID_W-1:0]   r_sid, r_skid_sid;
  logic [NUM_CAT-1:0] r_mask, r_skid_mask;
  logic               r_eop_acc, r_trunc;
  logic [7:0]         r_char;
  logic [15:0]        r_cnt;

  logic       w_ready, w_xfer, w_act, w_emit, w_word_end, w_trunc, w_bypass, w_seen, w_load;
  logic [7:0] w_byte;

  assign w_xfer     = in_valid & in_ready;
  assign w_act      = (r_state == S_LOAD) | (r_state == S_STREAM);
  assign w_emit     = (r_state == S_STREAM) & r_hold_vld;
  assign w_byte     = lane_byte(r_hold, r_lane);
  assign w_word_end = w_emit & (r_lane == (r_hold_eop ? r_hold_nb : LANE_LAST));
  // An sop before the current eop word truncates; an sop after it is simply the next packet.
  assign w_trunc    = w_act & w_xfer & in_sop & ~r_eop_acc;
  assign w_bypass   = (r_state == S_STREAM) & w_xfer & ~in_sop & ~r_eop_acc &
                      (~r_hold_vld | w_word_end);
  assign w_load     = (r_state == S_LOAD);

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_IDLE:           w_ready = r_live;
      S_LOAD, S_STREAM: w_ready = ~r_skid_vld;
      default:          w_ready = 1'b0;
    endcase
  end
  assign in_ready = w_ready;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_xfer & in_sop) w_nxt = S_LOAD;
      S_LOAD:   w_nxt = S_STREAM;
      S_STREAM: if (w_trunc | r_trunc | (w_word_end & r_hold_eop)) w_nxt = S_EOP;
      S_EOP:    w_nxt = (r_skid_vld & r_skid_sop) ? S_LOAD : S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;       r_hold <= '0;        r_hold_vld <= 1'b0;
      r_hold_eop <= 1'b0;   r_hold_nb <= '0;     r_lane <= LANE_FIRST;
      r_skid <= '0;         r_skid_vld <= 1'b0;  r_skid_sop <= 1'b0;
      r_skid_eop <= 1'b0;   r_skid_nb <= '0;     r_skid_sid <= '0;
      r_skid_mask <= '0;    r_sid <= '0;         r_mask <= '0;
      r_eop_acc <= 1'b0;    r_trunc <= 1'b0;     r_char <= '0;
      r_cnt <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: if (w_xfer & in_sop) begin
          r_hold <= in_data;     r_hold_vld <= 1'b1; r_hold_eop <= in_eop;
          r_hold_nb <= in_nbytes; r_lane <= LANE_FIRST;
          r_sid <= in_sid;       r_mask <= in_en_mask;
          r_eop_acc <= in_eop;   r_trunc <= 1'b0;
        end
        S_LOAD, S_STREAM: begin
          if (w_emit) begin
            r_char <= w_byte;
            r_lane <= w_word_end ? LANE_FIRST : r_lane + 2'd1;
          end
          if (w_word_end) begin
            if (r_skid_vld & ~r_skid_sop) begin
              r_hold <= r_skid; r_hold_eop <= r_skid_eop; r_hold_nb <= r_skid_nb;
              r_skid_vld <= 1'b0;
            end else if (!w_bypass) begin
              r_hold_vld <= 1'b0;
            end
          end
          if (w_bypass) begin
            r_hold <= in_data; r_hold_vld <= 1'b1; r_hold_eop <= in_eop; r_hold_nb <= in_nbytes;
          end
          if (w_xfer & (in_sop | ~r_eop_acc) & ~w_bypass) begin
            r_skid <= in_data;    r_skid_vld <= 1'b1;  r_skid_sop <= in_sop;
            r_skid_eop <= in_eop; r_skid_nb <= in_nbytes;
            r_skid_sid <= in_sid; r_skid_mask <= in_en_mask;
          end
          if (w_xfer & ~in_sop & ~r_eop_acc) r_eop_acc <= in_eop;
          if (w_trunc) r_trunc <= 1'b1;
        end
        S_EOP: begin
          r_cnt   <= r_cnt + 16'd1;
          r_trunc <= 1'b0;
          r_lane  <= LANE_FIRST;
          r_skid_vld <= 1'b0;
          if (r_skid_vld & r_skid_sop) begin
            r_hold <= r_skid;        r_hold_vld <= 1'b1; r_hold_eop <= r_skid_eop;
            r_hold_nb <= r_skid_nb;  r_sid <= r_skid_sid; r_mask <= r_skid_mask;
            r_eop_acc <= r_skid_eop;
          end
        end
        default: ;
      endcase
    end
  end

  dpi_stream_table #(.SID_W(SID_W)) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_sid  (r_sid),
    .rd_seen (w_seen),
    .set_en  (w_load),
    .clr_all (clr_streams)
  );

  assign load_state    = w_load;
  assign new_stream_id = w_load & ~w_seen;
  assign stream_id     = r_sid;
  assign enable        = r_mask;
  assign char_in_vld   = w_emit;
  assign char_in       = w_emit ? w_byte : r_char;
  assign eop           = (r_state == S_EOP);
  assign pkt_count     = r_cnt;
  assign busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_dpi_pkt_sequencer.sv
// Scoreboard bench: packets from a vector table push expected events, a negedge monitor pops them.
module tb_dpi_pkt_sequencer;
  localparam int SID_W = 6;
  localparam int NUM_CAT = 8;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic               in_valid = 1'b0, in_ready;
  logic [31:0]        in_data = '0;
  logic               in_sop = 1'b0, in_eop = 1'b0;
  logic [1:0]         in_nbytes = '0;
  logic [SID_W-1:0]   in_sid = '0;
  logic [NUM_CAT-1:0] in_en_mask = '0;
  logic               clr_streams = 1'b0;
  logic               load_state, new_stream_id, char_in_vld, eop, busy;
  logic [SID_W-1:0]   stream_id;
  logic [7:0]         char_in;
  logic [NUM_CAT-1:0] enable;
  logic [15:0]        pkt_count;

  dpi_pkt_sequencer #(.NUM_CAT(NUM_CAT), .SID_W(SID_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_nbytes(in_nbytes), .in_sid(in_sid),
    .in_en_mask(in_en_mask), .clr_streams(clr_streams), .load_state(load_state),
    .new_stream_id(new_stream_id), .stream_id(stream_id), .char_in(char_in),
    .char_in_vld(char_in_vld), .eop(eop), .enable(enable), .pkt_count(pkt_count), .busy(busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] sid; logic [7:0] mask; int len; bit clr; bit b2b; bit exp_new;
  } vec_t;
  typedef struct {
    int kind; logic [7:0] data; logic nw; logic [5:0] sid; logic [7:0] mask;
  } ev_t;

  ev_t sb[$];
  int  n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic take(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e = '{0, 8'h00, 1'b0, 6'd0, 8'h00};
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL sb_unexpected: event kind %0d with nothing expected (cycle %0d)", kind, cyc);
    end else begin
      e = sb.pop_front();
      check("ev_kind", 32'(kind), 32'(e.kind));
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: kind 0 = load_state, 1 = char, 2 = eop.
  bit mon_en = 1'b0;
  bit first_pend = 1'b0;
  int m = 0, last_char_cyc = -10;
  int sop_cyc[16], load_cyc[16], first_cyc[16], eop_cyc[16], gap[16];

  always @(negedge clk) begin
    ev_t e;
    bit ok;
    if (mon_en && rst_n) begin
      if (load_state) begin
        take(0, e, ok);
        if (ok) begin
          check("new_stream_id", 32'(new_stream_id), 32'(e.nw));
          check("load_sid", 32'(stream_id), 32'(e.sid));
          check("load_enable", 32'(enable), 32'(e.mask));
        end
        if (m < 16) load_cyc[m] = cyc;
        first_pend = 1'b1;
      end
      if (char_in_vld) begin
        take(1, e, ok);
        if (ok) check("char", 32'(char_in), 32'(e.data));
        if (first_pend && m < 16) begin
          first_cyc[m] = cyc;
          gap[m] = cyc - last_char_cyc;
        end
        first_pend = 1'b0;
        last_char_cyc = cyc;
      end
      if (eop) begin
        take(2, e, ok);
        if (ok) begin
          check("eop_sid", 32'(stream_id), 32'(e.sid));
          check("eop_enable", 32'(enable), 32'(e.mask));
        end
        check("eop_after_last_char", 32'(cyc - last_char_cyc), 32'd1);
        if (m < 16) eop_cyc[m] = cyc;
        m++;
      end
    end
  end

  task automatic drive_word(input logic [31:0] d, input logic s, input logic e,
                            input logic [1:0] nb, input logic [5:0] sid,
                            input logic [7:0] mask, output int acc);
    bit ok = 1'b0;
    acc = -1;
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
    in_nbytes = nb; in_sid = sid; in_en_mask = mask;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) acc = cyc;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int p, input vec_t v);
    logic [7:0]  b[$];
    logic [31:0] w;
    int          nw, acc, idx;
    bit          last;
    for (int k = 0; k < v.len; k++) b.push_back(8'(p * 37 + k * 11 + 1));
    if (v.clr) begin
      clr_streams = 1'b1;
      @(posedge clk);
      #1 clr_streams = 1'b0;
    end
    sb.push_back('{0, 8'h00, v.exp_new, v.sid, v.mask});
    foreach (b[k]) sb.push_back('{1, b[k], 1'b0, v.sid, v.mask});
    sb.push_back('{2, 8'h00, 1'b0, v.sid, v.mask});
    nw = (v.len + 3) / 4;
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        idx = wi * 4 + j;
        w = {w[23:0], (idx < v.len) ? b[idx] : 8'h00};
      end
      last = (wi == nw - 1);
      drive_word(w, wi == 0, last, last ? 2'((v.len - 1) % 4) : 2'd0, v.sid, v.mask, acc);
      if (wi == 0 && p < 16) sop_cyc[p] = acc;
    end
    if (!v.b2b) begin
      in_valid = 1'b0;
      wait_drain();
    end
  endtask

  vec_t tbl[6];

  initial begin
    int acc;
    vec_t v;
    tbl[0] = '{6'd3,  8'hA5, 5, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{6'd3,  8'h3C, 4, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{6'd7,  8'hFF, 1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{6'd3,  8'h5A, 9, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{6'd12, 8'h81, 6, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{6'd12, 8'h18, 3, 1'b0, 1'b0, 1'b0};

    #2;
    check("reset_outputs", 32'({load_state, new_stream_id, char_in_vld, eop, busy, in_ready,
                               char_in, stream_id, enable}), 32'd0);
    check("reset_pkt_count", 32'(pkt_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;

    for (int i = 0; i < 6; i++) send_pkt(i, tbl[i]);

    for (int i = 0; i < 6; i++) begin
      if (i == 0 || !tbl[i-1].b2b) begin
        check("lat_load", 32'(load_cyc[i] - sop_cyc[i]), 32'd1);
        check("lat_first_char", 32'(first_cyc[i] - sop_cyc[i]), 32'd2);
        check("lat_eop", 32'(eop_cyc[i] - sop_cyc[i]), 32'(2 + tbl[i].len));
      end
    end
    check("b2b_gap", 32'(gap[5]), 32'd3);
    check("pkt_count_6", 32'(pkt_count), 32'd6);

    // Last word with only byte 0 valid.
    sb.push_back('{0, 8'h00, 1'b1, 6'd9, 8'h0F});
    sb.push_back('{1, 8'hAA, 1'b0, 6'd9, 8'h0F});
    sb.push_back('{2, 8'h00, 1'b0, 6'd9, 8'h0F});
    drive_word(32'hAABBCCDD, 1'b1, 1'b1, 2'd0, 6'd9, 8'h0F, acc);
    in_valid = 1'b0;
    wait_drain();
    check("pkt_count_7", 32'(pkt_count), 32'd7);

    // Reset while streaming a packet on sid 3.
    mon_en = 1'b0;
    drive_word(32'h11223344, 1'b1, 1'b0, 2'd0, 6'd3, 8'h11, acc);
    drive_word(32'h55667788, 1'b0, 1'b0, 2'd0, 6'd3, 8'h11, acc);
    in_valid = 1'b0;
    for (int i = 0; i < 50 && !char_in_vld; i++) @(negedge clk);
    check("reached_stream", 32'(char_in_vld), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midpkt_reset_outputs", 32'({load_state, new_stream_id, char_in_vld, eop, busy,
                                      in_ready, char_in, stream_id, enable}), 32'd0);
    check("midpkt_reset_count", 32'(pkt_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;
    v = '{6'd3, 8'h42, 5, 1'b0, 1'b0, 1'b1};
    send_pkt(7, v);
    check("pkt_count_after_reset", 32'(pkt_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
